// File: rtl/aes_pkg.sv
// Shared AES types and widths for the round-key store and its register file.
package aes_pkg;

    localparam int unsigned AES_KEY_W     = 128;
    localparam int unsigned AES128_ROUNDS = 10;
    localparam int unsigned ROUND_IDX_W   = 4;

    typedef logic [ROUND_IDX_W-1:0] round_idx_t;

    typedef enum logic [2:0] {
        KS_IDLE    = 3'd0,
        KS_START   = 3'd1,
        KS_WAIT    = 3'd2,
        KS_CAPTURE = 3'd3,
        KS_VALID   = 3'd4
    } ks_state_e;

endpackage

// File: rtl/aes_round_key_store_128_if.sv
// Bundle of the load, key-expander and round-key read signals of the round-key store.
interface aes_round_key_store_128_if
    import aes_pkg::*;
#(
    parameter int unsigned KEY_W = AES_KEY_W
);
    logic             load;
    logic [KEY_W-1:0] cipher_key;
    logic             busy;
    logic             keys_valid;
    logic             err;
    logic             kexp_start;
    logic [KEY_W-1:0] kexp_key;
    logic [KEY_W-1:0] kexp_subkey;
    logic             kexp_rdy;
    logic             rd_en;
    round_idx_t       rd_round;
    logic [KEY_W-1:0] rd_key;
    logic             rd_valid;
    logic             rd_err;

    modport slave (
        input  load, cipher_key, kexp_subkey, kexp_rdy, rd_en, rd_round,
        output busy, keys_valid, err, kexp_start, kexp_key, rd_key, rd_valid, rd_err
    );

    modport master (
        output load, cipher_key, kexp_subkey, kexp_rdy, rd_en, rd_round,
        input  busy, keys_valid, err, kexp_start, kexp_key, rd_key, rd_valid, rd_err
    );
endinterface

// File: rtl/aes_round_key_regfile.sv
// Round-key storage: one synchronous write port and one registered read port that
// returns zero and flags an error for out-of-range or blocked reads.
module aes_round_key_regfile
    import aes_pkg::*;
#(
    parameter int unsigned KEY_W      = AES_KEY_W,
    parameter int unsigned NUM_ROUNDS = AES128_ROUNDS
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  round_idx_t       wr_idx,
    input  logic [KEY_W-1:0] wr_data,
    input  logic             rd_en,
    input  round_idx_t       rd_idx,
    input  logic             rd_block,
    output logic [KEY_W-1:0] rd_data,
    output logic             rd_valid,
    output logic             rd_err
);
    localparam int unsigned DEPTH = NUM_ROUNDS + 1;

    logic [KEY_W-1:0] mem [DEPTH];
    logic             rd_bad;

    assign rd_bad = (32'(rd_idx) > NUM_ROUNDS) || rd_block;

    // Storage is deliberately not reset; keys_valid qualifies its contents.
    always_ff @(posedge clk) begin
        if (wr_en && (32'(wr_idx) <= NUM_ROUNDS)) begin
            mem[wr_idx] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
            rd_err   <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            rd_err   <= rd_en && rd_bad;
            if (rd_en) begin
                rd_data <= rd_bad ? '0 : mem[rd_idx];
            end
        end
    end

endmodule

// File: rtl/aes_round_key_store_128.sv
// AES-128 round-key store: starts the key expander on load, captures the cipher key
// and the streamed subkeys as rounds 0..NUM_ROUNDS, and serves them on a read port.
module aes_round_key_store_128
    import aes_pkg::*;
#(
    parameter int unsigned KEY_W      = AES_KEY_W,
    parameter int unsigned NUM_ROUNDS = AES128_ROUNDS,
    parameter int unsigned TIMEOUT    = 16
) (
    input logic                      clk,
    input logic                      reset,
    aes_round_key_store_128_if.slave bus
);
    localparam int unsigned TMR_W = $clog2(TIMEOUT + 1);

    localparam logic [2:0] ST_IDLE    = 3'(KS_IDLE);
    localparam logic [2:0] ST_START   = 3'(KS_START);
    localparam logic [2:0] ST_WAIT    = 3'(KS_WAIT);
    localparam logic [2:0] ST_CAPTURE = 3'(KS_CAPTURE);
    localparam logic [2:0] ST_VALID   = 3'(KS_VALID);

    localparam round_idx_t       LAST_RND = round_idx_t'(NUM_ROUNDS);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

    logic [2:0]       state, state_d;
    round_idx_t       rnd, rnd_d;
    logic [TMR_W-1:0] timer, timer_d;
    logic             busy, busy_d;
    logic             keys_valid, keys_valid_d;
    logic             err, err_d;
    logic             kexp_start, kexp_start_d;
    logic [KEY_W-1:0] kexp_key, kexp_key_d;

    logic             wr_en;
    round_idx_t       wr_idx;
    logic [KEY_W-1:0] wr_data;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            rnd        <= '0;
            timer      <= '0;
            busy       <= 1'b0;
            keys_valid <= 1'b0;
            err        <= 1'b0;
            kexp_start <= 1'b0;
            kexp_key   <= '0;
        end else begin
            state      <= state_d;
            rnd        <= rnd_d;
            timer      <= timer_d;
            busy       <= busy_d;
            keys_valid <= keys_valid_d;
            err        <= err_d;
            kexp_start <= kexp_start_d;
            kexp_key   <= kexp_key_d;
        end
    end

    always_comb begin
        state_d      = state;
        rnd_d        = rnd;
        timer_d      = timer;
        busy_d       = busy;
        keys_valid_d = keys_valid;
        err_d        = err;
        kexp_start_d = 1'b0;
        kexp_key_d   = kexp_key;
        wr_en        = 1'b0;
        wr_idx       = rnd;
        wr_data      = bus.kexp_subkey;

        case (state)
            ST_IDLE, ST_VALID: begin
                // Accepting a load invalidates the schedule and writes slot 0 at once.
                if (bus.load) begin
                    kexp_key_d   = bus.cipher_key;
                    wr_en        = 1'b1;
                    wr_idx       = '0;
                    wr_data      = bus.cipher_key;
                    keys_valid_d = 1'b0;
                    err_d        = 1'b0;
                    busy_d       = 1'b1;
                    kexp_start_d = 1'b1;
                    state_d      = ST_START;
                end
            end
            ST_START: begin
                rnd_d   = round_idx_t'(1);
                timer_d = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT, ST_CAPTURE: begin
                if (bus.kexp_rdy) begin
                    wr_en = 1'b1;
                    if (rnd == LAST_RND) begin
                        busy_d       = 1'b0;
                        keys_valid_d = 1'b1;
                        state_d      = ST_VALID;
                    end else begin
                        rnd_d   = rnd + round_idx_t'(1);
                        state_d = ST_CAPTURE;
                    end
                end else if ((state == ST_CAPTURE) || (timer == TMR_LAST)) begin
                    // Early drop of kexp_rdy or no response in time: abort.
                    err_d   = 1'b1;
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    timer_d = timer + TMR_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bus.busy       = busy;
    assign bus.keys_valid = keys_valid;
    assign bus.err        = err;
    assign bus.kexp_start = kexp_start;
    assign bus.kexp_key   = kexp_key;

    aes_round_key_regfile #(
        .KEY_W      (KEY_W),
        .NUM_ROUNDS (NUM_ROUNDS)
    ) u_regfile (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (wr_en),
        .wr_idx   (wr_idx),
        .wr_data  (wr_data),
        .rd_en    (bus.rd_en),
        .rd_idx   (bus.rd_round),
        .rd_block (!keys_valid),
        .rd_data  (bus.rd_key),
        .rd_valid (bus.rd_valid),
        .rd_err   (bus.rd_err)
    );

endmodule
